mix_bus_pipe: RTL and testbench

Parametrised, pipelined multichannel mixing bus. Takes one signed sample per channel with a valid strobe, applies per-channel 4-bit volume, mute and solo, sums all channels, scales to the output word and saturates. It sits between the per-channel effects chain and the output clock-crossing buffer. It supersedes the fixed 4-channel, unity-gain mixer and adds volume, clip reporting and an optional peak meter.

---
 rtl/mix_bus_pipe_if.sv | 31 +++
 rtl/mix_bus_pipe.sv | 147 ++++++++++++++
 tb/tb_mix_bus_pipe.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mix_bus_pipe_if.sv
// Sample/control bus of the multichannel mixer.
// master drives samples and controls, slave is the mixer.
interface mix_bus_pipe_if #(
    parameter int WIDTH     = 8,
    parameter int CHANNELS  = 4,
    parameter int OUT_WIDTH = 16
);
    logic [CHANNELS-1:0][WIDTH-1:0] data_in;
    logic                           valid_in;
    logic [CHANNELS-1:0][3:0]       volume;
    logic [CHANNELS-1:0]            mute;
    logic                           solo_enable;
    logic [CHANNELS-1:0]            solo;
    logic                           peak_clr;
    logic [OUT_WIDTH-1:0]           data_out;
    logic                           valid_out;
    logic                           clip_out;
    logic [OUT_WIDTH-2:0]           peak_out;

    modport master (
        output data_in, valid_in, volume, mute,
        output solo_enable, solo, peak_clr,
        input  data_out, valid_out, clip_out, peak_out
    );

    modport slave (
        input  data_in, valid_in, volume, mute,
        input  solo_enable, solo, peak_clr,
        output data_out, valid_out, clip_out, peak_out
    );
endinterface

// File: rtl/mix_bus_pipe.sv
// 3-stage mixing bus: gain/gate, sum, scale+saturate.
// Peak meter is built only with MIXER_PEAK_METER_EN defined.
module mix_bus_pipe #(
    parameter int WIDTH      = 8,
    parameter int CHANNELS   = 4,
    parameter int OUT_WIDTH  = 16,
    parameter int DECAY_LOG2 = 10
) (
    input  logic          clk_in,
    input  logic          rst_n_in,
    mix_bus_pipe_if.slave bus
);
    localparam int PW   = WIDTH + 5;
    localparam int ACCW = PW + $clog2(CHANNELS) + 1;
    localparam int S    = OUT_WIDTH - WIDTH - 3;
    localparam int SH   = (S > 0) ? S : 0;
    localparam int SW   = ACCW + SH;

    localparam logic signed [SW-1:0] MAXV =
        {{(SW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] MINV =
        {{(SW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    logic [CHANNELS-1:0]    w_act;
    logic signed [PW-1:0]   w_p [CHANNELS];
    logic signed [PW-1:0]   r_p [CHANNELS];
    logic                   r_v1;
    logic                   r_v2;
    logic                   r_v3;
    logic signed [ACCW-1:0] w_sum;
    logic signed [ACCW-1:0] r_acc;
    logic signed [SW-1:0]   w_scaled;
    logic [OUT_WIDTH-1:0]   w_sat;
    logic                   w_clip;
    logic [OUT_WIDTH-1:0]   r_dout;
    logic                   r_clip;

    // Mute beats solo; solo mode with no soloed channel is silence
    assign w_act = ~bus.mute
                 & ({CHANNELS{~bus.solo_enable}} | bus.solo);

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            w_p[i] = '0;
            if (w_act[i])
                w_p[i] = PW'($signed(bus.data_in[i]))
                       * PW'($signed({1'b0, bus.volume[i]}));
        end
    end

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < CHANNELS; i++)
            w_sum = w_sum + ACCW'(r_p[i]);
    end

    generate
        if (S >= 0) begin : g_shl
            assign w_scaled = SW'(r_acc) <<< S;
        end else begin : g_shr
            assign w_scaled = r_acc >>> (-S);
        end
    endgenerate

    always_comb begin
        w_sat  = w_scaled[OUT_WIDTH-1:0];
        w_clip = 1'b0;
        if (w_scaled > MAXV) begin
            w_sat  = MAXV[OUT_WIDTH-1:0];
            w_clip = 1'b1;
        end else if (w_scaled < MINV) begin
            w_sat  = MINV[OUT_WIDTH-1:0];
            w_clip = 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < CHANNELS; i++)
                r_p[i] <= '0;
            r_v1   <= 1'b0;
            r_v2   <= 1'b0;
            r_v3   <= 1'b0;
            r_acc  <= '0;
            r_dout <= '0;
            r_clip <= 1'b0;
        end else begin
            r_v1 <= bus.valid_in;
            r_v2 <= r_v1;
            r_v3 <= r_v2;
            if (bus.valid_in)
                for (int i = 0; i < CHANNELS; i++)
                    r_p[i] <= w_p[i];
            if (r_v1)
                r_acc <= w_sum;
            if (r_v2) begin
                r_dout <= w_sat;
                r_clip <= w_clip;
            end
        end
    end

    assign bus.data_out  = r_dout;
    assign bus.valid_out = r_v3;
    assign bus.clip_out  = r_clip;

`ifdef MIXER_PEAK_METER_EN
    logic [OUT_WIDTH-2:0]  r_peak;
    logic [OUT_WIDTH-2:0]  w_mag;
    logic [OUT_WIDTH-1:0]  w_neg;
    logic [DECAY_LOG2-1:0] r_dcnt;

    assign w_neg = -r_dout;

    // Negating the most negative code leaves the sign set
    always_comb begin
        w_mag = r_dout[OUT_WIDTH-2:0];
        if (r_dout[OUT_WIDTH-1])
            w_mag = w_neg[OUT_WIDTH-1] ? '1
                                       : w_neg[OUT_WIDTH-2:0];
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_peak <= '0;
            r_dcnt <= '0;
        end else begin
            if (r_v3)
                r_dcnt <= r_dcnt + DECAY_LOG2'(1);
            if (bus.peak_clr)
                r_peak <= '0;
            else if (r_v3) begin
                if (w_mag > r_peak)
                    r_peak <= w_mag;
                else if (&r_dcnt && r_peak != '0)
                    r_peak <= r_peak - (OUT_WIDTH-1)'(1);
            end
        end
    end

    assign bus.peak_out = r_peak;
`else
    logic w_unused_clr;
    assign w_unused_clr = bus.peak_clr;
    assign bus.peak_out = '0;
`endif
endmodule

// File: tb/tb_mix_bus_pipe.sv
// Scoreboard bench for mix_bus_pipe with a behavioural
// reference mixer; peak checks need MIXER_PEAK_METER_EN.
module tb_mix_bus_pipe;
    localparam int W  = 8;
    localparam int CH = 4;
    localparam int OW = 16;
    localparam int DL = 10;

    typedef struct {
        int d;
        int c;
        int t;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   n_out = 0;
    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    mix_bus_pipe_if #(
        .WIDTH(W), .CHANNELS(CH), .OUT_WIDTH(OW)
    ) bus ();

    mix_bus_pipe #(
        .WIDTH(W), .CHANNELS(CH),
        .OUT_WIDTH(OW), .DECAY_LOG2(DL)
    ) dut (
        .clk_in(clk),
        .rst_n_in(rst_n),
        .bus(bus)
    );

    task automatic check(string tag,
                         logic signed [31:0] got,
                         logic signed [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d",
                     tag, got, exp);
        end
    endtask

    function automatic void model(
        input int d[4], input int v[4],
        input logic [3:0] mu, input logic se,
        input logic [3:0] so,
        output int y, output int c);
        int acc;
        int sc;
        acc = 0;
        for (int i = 0; i < 4; i++)
            if (!mu[i] && (!se || so[i]))
                acc += d[i] * v[i];
        sc = acc * 32;
        c = 0;
        y = sc;
        if (sc > 32767) begin
            y = 32767;
            c = 1;
        end else if (sc < -32768) begin
            y = -32768;
            c = 1;
        end
    endfunction

    task automatic send(input int d[4], input int v[4],
                        input logic [3:0] mu, input logic se,
                        input logic [3:0] so);
        exp_t e;
        @(posedge clk);
        #1;
        for (int i = 0; i < CH; i++) begin
            bus.data_in[i] = d[i][W-1:0];
            bus.volume[i]  = v[i][3:0];
        end
        bus.mute        = mu;
        bus.solo_enable = se;
        bus.solo        = so;
        bus.valid_in    = 1'b1;
        bus.peak_clr    = 1'b0;
        model(d, v, mu, se, so, e.d, e.c);
        e.t = cyc;
        q.push_back(e);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        bus.valid_in = 1'b0;
        bus.peak_clr = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() != 0; i++)
            idle();
        idle();
        check("drain", q.size(), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.valid_out) begin
            n_out++;
            if (q.size() == 0)
                check("unexpected_valid", 1, 0);
            else begin
                e = q.pop_front();
                check("data", $signed(bus.data_out), e.d);
                check("clip", bus.clip_out, e.c);
                check("latency", cyc - e.t, 3);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1);
    end

    initial begin
        int d[4];
        int v[4];
        int base;
        bus.data_in     = '0;
        bus.valid_in    = 1'b0;
        bus.volume      = '0;
        bus.mute        = '0;
        bus.solo_enable = 1'b0;
        bus.solo        = '0;
        bus.peak_clr    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data", $signed(bus.data_out), 0);
        check("rst_valid", bus.valid_out, 0);
        check("rst_clip", bus.clip_out, 0);
        check("rst_peak", bus.peak_out, 0);
        rst_n = 1'b1;

        send('{127, 0, 0, 0}, '{8, 8, 8, 8}, 4'b1110, 0, 0);
        drain();
        repeat (3) idle();
        check("hold", $signed(bus.data_out), 32512);

        send('{-128, 5, 5, 5}, '{8, 8, 8, 8}, 4'b1110, 0, 0);
        send('{127, 127, 127, 127},
             '{15, 15, 15, 15}, 4'b0000, 0, 0);
        drain();
`ifndef MIXER_PEAK_METER_EN
        check("peak_off", bus.peak_out, 0);
`endif

        send('{100, -64, 100, 100}, '{8, 8, 8, 8},
             4'b0010, 1, 4'b0010);
        send('{100, -64, 100, 100}, '{8, 8, 8, 8},
             4'b0000, 1, 4'b0010);
        send('{100, -64, 100, 100}, '{8, 8, 8, 8},
             4'b0000, 1, 4'b0000);
        send('{100, 50, 50, 50}, '{0, 8, 8, 8},
             4'b1110, 0, 0);
        drain();

        base = n_out;
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 4; i++) begin
                d[i] = int'($urandom_range(0, 255)) - 128;
                v[i] = int'($urandom_range(0, 15));
            end
            send(d, v, 4'($urandom), 1'($urandom),
                 4'($urandom));
        end
        drain();
        check("stream_count", n_out - base, 8);

        base = n_out;
        send('{50, 0, 0, 0}, '{8, 8, 8, 8}, 4'b1110, 0, 0);
        send('{60, 0, 0, 0}, '{8, 8, 8, 8}, 4'b1110, 0, 0);
        send('{70, 0, 0, 0}, '{8, 8, 8, 8}, 4'b1110, 0, 0);
        send('{80, 0, 0, 0}, '{8, 8, 8, 8}, 4'b1110, 0, 0);
        @(posedge clk);
        #1;
        bus.valid_in = 1'b0;
        rst_n = 1'b0;
        q.delete();
        #1;
        check("pre_reset_outs", n_out - base, 1);
        check("mid_rst_data", $signed(bus.data_out), 0);
        check("mid_rst_valid", bus.valid_out, 0);
        check("mid_rst_clip", bus.clip_out, 0);
        check("mid_rst_peak", bus.peak_out, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send('{-20, 0, 0, 0}, '{8, 8, 8, 8}, 4'b1110, 0, 0);
        send('{30, 10, 0, 0}, '{8, 4, 8, 8}, 4'b1100, 0, 0);
        drain();
        check("post_reset_outs", n_out - base, 3);

`ifdef MIXER_PEAK_METER_EN
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send('{127, 0, 0, 0}, '{8, 8, 8, 8}, 4'b1110, 0, 0);
        drain();
        check("peak_load", bus.peak_out, 32512);
        for (int k = 0; k < 1022; k++)
            send('{0, 0, 0, 0}, '{8, 8, 8, 8}, 4'b1111, 0, 0);
        drain();
        check("peak_no_decay", bus.peak_out, 32512);
        send('{0, 0, 0, 0}, '{8, 8, 8, 8}, 4'b1111, 0, 0);
        drain();
        check("peak_decay", bus.peak_out, 32511);
        @(posedge clk);
        #1;
        bus.peak_clr = 1'b1;
        idle();
        check("peak_clr", bus.peak_out, 0);
        send('{-128, 0, 0, 0}, '{8, 8, 8, 8}, 4'b1110, 0, 0);
        drain();
        check("peak_negfs", bus.peak_out, 32767);
        @(posedge clk);
        #1;
        bus.peak_clr = 1'b1;
        idle();
        check("peak_clr2", bus.peak_out, 0);
        send('{127, 0, 0, 0}, '{8, 8, 8, 8}, 4'b1110, 0, 0);
        idle();
        idle();
        @(posedge clk);
        #1;
        bus.peak_clr = 1'b1;
        idle();
        check("peak_clr_wins", bus.peak_out, 0);
        drain();
`endif

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end
endmodule
